// File: rtl/xstream_port_pkg.sv
// Shared definitions for the stream port: register offsets, STATUS/CTRL bit
// positions and the STATUS word packer.
package xstream_port_pkg;

  typedef enum logic [1:0] {
    SP_DATA   = 2'd0,
    SP_STATUS = 2'd1,
    SP_CTRL   = 2'd2,
    SP_RSVD   = 2'd3
  } sp_addr_e;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_TX_LVL   = 8;
  localparam int ST_RX_LVL   = 16;
  localparam int LVL_FIELD_W = 8;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_CLR_FLAG = 2;

  function automatic logic [31:0] status_word(
    input logic tx_full, input logic tx_empty,
    input logic rx_full, input logic rx_empty,
    input logic tx_ovf,  input logic rx_udf,
    input logic [LVL_FIELD_W-1:0] tx_lvl,
    input logic [LVL_FIELD_W-1:0] rx_lvl
  );
    logic [31:0] w;
    w = '0;
    w[ST_TX_FULL]  = tx_full;
    w[ST_TX_EMPTY] = tx_empty;
    w[ST_RX_FULL]  = rx_full;
    w[ST_RX_EMPTY] = rx_empty;
    w[ST_TX_OVF]   = tx_ovf;
    w[ST_RX_UDF]   = rx_udf;
    w[ST_TX_LVL +: LVL_FIELD_W] = tx_lvl;
    w[ST_RX_LVL +: LVL_FIELD_W] = rx_lvl;
    return w;
  endfunction

endpackage

// File: rtl/xstream_port_if.sv
// Controller bus plus TX/RX stream signals of the stream port.
interface xstream_port_if #(parameter int DATA_W = 32);
  logic              sel;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;

  modport slave (
    input  sel, we, addr, wdata, tx_ready, rx_valid, rx_data,
    output rdata, tx_valid, tx_data, rx_ready
  );

  modport master (
    output sel, we, addr, wdata, tx_ready, rx_valid, rx_data,
    input  rdata, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/xstream_port_fifo.sv
// Single-clock FIFO with combinational head. Push to full / pop from empty are
// ignored; flush overrides both and restarts the pointers.
module xfifo_sync #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  push_ok, pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/xstream_port.sv
// Memory-mapped stream port: CPU-filled TX FIFO draining to a valid/ready
// stream, stream-filled RX FIFO drained by CPU reads of DATA.
module xstream_port
  import xstream_port_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input logic           clk,
  input logic           rst,
  xstream_port_if.slave bus
);
  logic              cpu_wr, cpu_rd;
  sp_addr_e          offs;
  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [DEPTH_LOG2:0] tx_level, rx_level;
  logic              ctrl_wr, clr_flags;
  logic              tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic [31:0]       status;

  assign offs     = sp_addr_e'(bus.addr);
  assign cpu_wr   = bus.sel & bus.we;
  assign cpu_rd   = bus.sel & ~bus.we;
  assign ctrl_wr  = cpu_wr && (offs == SP_CTRL);

  assign tx_push   = cpu_wr && (offs == SP_DATA);
  assign tx_pop    = bus.tx_valid & bus.tx_ready;
  assign tx_flush  = ctrl_wr & bus.wdata[CTRL_TX_FLUSH];
  assign rx_push   = bus.rx_valid & bus.rx_ready;
  assign rx_pop    = cpu_rd && (offs == SP_DATA);
  assign rx_flush  = ctrl_wr & bus.wdata[CTRL_RX_FLUSH];
  assign clr_flags = ctrl_wr & bus.wdata[CTRL_CLR_FLAG];

  // Gating with rst keeps any handshake from completing in a reset cycle.
  assign bus.tx_valid = ~tx_empty & ~rst;
  assign bus.tx_data  = tx_head;
  assign bus.rx_ready = ~rx_full & ~rst;

  xfifo_sync #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(bus.wdata), .head(tx_head), .full(tx_full), .empty(tx_empty),
    .level(tx_level)
  );

  xfifo_sync #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(bus.rx_data), .head(rx_head), .full(rx_full), .empty(rx_empty),
    .level(rx_level)
  );

  // A new event in the same cycle as a clear must leave the flag set.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (clr_flags) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
    end
    if (tx_push && tx_full)  tx_ovf_d = 1'b1;
    if (rx_pop  && rx_empty) rx_udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  assign status = status_word(tx_full, tx_empty, rx_full, rx_empty,
                              tx_ovf_q, rx_udf_q,
                              LVL_FIELD_W'(tx_level), LVL_FIELD_W'(rx_level));

  always_comb begin
    bus.rdata = '0;
    case (offs)
      SP_DATA:   bus.rdata = rx_empty ? '0 : rx_head;
      SP_STATUS: bus.rdata = DATA_W'(status);
      default:   bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_xstream_port.sv
// Directed bench for xstream_port: reset, TX/RX paths, overflow/underflow,
// concurrency, flush and pointer wrap.
module tb_xstream_port;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  xstream_port_if #(.DATA_W(32)) bus ();

  xstream_port #(.DATA_W(32), .DEPTH_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
    tick();
    bus.sel = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.sel = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 0;

    // Reset
    tick();
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    rd(2'd1, 32'h0000_000A, "rst_status");

    // TX path
    wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33);
    rd(2'd1, 32'h0000_0308, "tx3_status");
    chk("tx3_valid", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b1;
    chk("tx_d0", bus.tx_data, 32'h11); tick();
    chk("tx_d1", bus.tx_data, 32'h22); tick();
    chk("tx_d2", bus.tx_data, 32'h33); tick();
    chk("tx_drained_valid", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;
    rd(2'd1, 32'h0000_000A, "tx_drained_status");

    // TX overflow
    for (int i = 0; i < 9; i++) wr(2'd0, 32'(i));
    rd(2'd1, 32'h0000_0819, "tx_ovf_status");
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_ovf_drain", bus.tx_data, 32'(i));
      tick();
    end
    chk("tx_ovf_drained_valid", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;
    rd(2'd1, 32'h0000_001A, "tx_ovf_sticky");
    wr(2'd2, 32'h4);
    rd(2'd1, 32'h0000_000A, "tx_ovf_cleared");

    // RX path
    bus.rx_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.rx_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    bus.rx_valid = 1'b0;
    #1;
    chk("rx_full_ready", 32'(bus.rx_ready), 32'd0);
    rd(2'd1, 32'h0008_0006, "rx_full_status");
    for (int i = 1; i <= 8; i++) rd(2'd0, 32'hA5A5_0000 + 32'(i), "rx_read");
    rd(2'd0, 32'h0, "rx_udf_read");
    rd(2'd1, 32'h0000_002A, "rx_udf_status");
    wr(2'd2, 32'h4);
    rd(2'd1, 32'h0000_000A, "rx_udf_cleared");

    // CTRL and reserved reads, reserved write ignored
    rd(2'd2, 32'h0, "ctrl_read");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0, "rsvd_read");
    rd(2'd1, 32'h0000_000A, "rsvd_wr_status");

    // Concurrent push and pop at TX level 4
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h100 + 32'(i));
    bus.tx_ready = 1'b1;
    wr(2'd0, 32'h104);
    bus.tx_ready = 1'b0;
    rd(2'd1, 32'h0000_0408, "conc_level");
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("conc_order", bus.tx_data, 32'h100 + 32'(i));
      tick();
    end
    chk("conc_drained_valid", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;

    // TX full with concurrent write and pop: write dropped
    for (int i = 0; i < 8; i++) wr(2'd0, 32'h200 + 32'(i));
    bus.tx_ready = 1'b1;
    wr(2'd0, 32'h2FF);
    bus.tx_ready = 1'b0;
    rd(2'd1, 32'h0000_0718, "full_conc_status");
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      chk("full_conc_order", bus.tx_data, 32'h200 + 32'(i));
      tick();
    end
    chk("full_conc_valid", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;
    wr(2'd2, 32'h4);

    // TX flush
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h1);
    rd(2'd1, 32'h0000_000A, "tx_flush_status");

    // RX flush with same-cycle push, then wrap with push/pop pairs
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = 32'hB0 + 32'(i);
      tick();
    end
    bus.rx_data = 32'hBEEF;
    wr(2'd2, 32'h2);
    bus.rx_valid = 1'b0;
    rd(2'd1, 32'h0000_000A, "rx_flush_status");
    bus.rx_valid = 1'b1;
    bus.rx_data = 32'hC00;
    tick();
    for (int i = 1; i <= 20; i++) begin
      bus.rx_data = 32'hC00 + 32'(i);
      rd(2'd0, 32'hC00 + 32'(i - 1), "rx_wrap_read");
    end
    bus.rx_valid = 1'b0;
    rd(2'd1, 32'h0001_0002, "rx_wrap_status");
    rd(2'd0, 32'hC14, "rx_wrap_last");
    rd(2'd1, 32'h0000_000A, "rx_wrap_empty");

    // Reset in the middle of a TX transfer
    wr(2'd0, 32'h55); wr(2'd0, 32'h66);
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    rd(2'd1, 32'h0000_000A, "mid_rst_status");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
